instr_arbiter: RTL and testbench
================================

INSTR_ARBITER -- requirements
Module: instr_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_REQ, 4, requester count (2..8)
- INSTRUCTION_WIDTH, 3, instruction type width
- STREAM_ID_WIDTH, 4, stream ID width
- CHANNEL_ID_WIDTH, 10, channel ID width
- INSTRUCTION_PARAMETER_WIDTH, 16, parameter width
- GAP_CYCLES, 0, forced IDLE cycles after each issue (0..15)
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock
- rstnIn, in, 1, reset; asynchronous, active-low
- req_Valid, in, NUM_REQ, per-requester instruction pending
- req_InstructionType, in, NUM_REQ*INSTRUCTION_WIDTH, packed types, requester i at slice i
- req_InstructionStreamID, in, NUM_REQ*STREAM_ID_WIDTH, packed stream IDs
- req_InstructionChannelID, in, NUM_REQ*CHANNEL_ID_WIDTH, packed channel IDs
- req_InstructionParameter, in, NUM_REQ*INSTRUCTION_PARAMETER_WIDTH, packed parameters
- req_Ack, out, NUM_REQ, one-cycle grant pulse per requester
- pause, in, 1, blocks new grants while high
- out_InstructionType, out, INSTRUCTION_WIDTH, backward-path instruction type
- out_InstructionStreamID, out, STREAM_ID_WIDTH, instruction stream ID
- out_InstructionChannelID, out, CHANNEL_ID_WIDTH, instruction channel ID
- out_InstructionParameter, out, INSTRUCTION_PARAMETER_WIDTH, instruction parameter
- issueCount, out, 32, issued instruction count, wraps at 2^32

Function
REQ-003 Requester eligible: req_Valid[i]=1, type != CMD_IDLE(0), req_Ack[i]=0 this cycle.
REQ-004 Urgent class: REWIND(5), RESTART(6), FINISH(7); normal class: REQUEST(2), LOOKAHEAD(3); other types never granted, never acked.
REQ-005 Any eligible urgent requester beats all normal requesters.
REQ-006 Within each class, round-robin with a separate pointer per class; search starts at pointer, ascending index, wraps NUM_REQ-1 -> 0.
REQ-007 After a grant to i, that class's pointer becomes (i+1) mod NUM_REQ; the other class's pointer is unchanged.
REQ-008 States: READY (grant allowed), GAP (count down GAP_CYCLES).
REQ-009 READY, pause=0, eligible requester exists: grant on clock edge.
REQ-010 Grant: out_* registers load winner's fields; req_Ack[winner]=1 for exactly that following cycle; issueCount +1.
REQ-011 Latency: request valid before edge k -> out_* and req_Ack valid during cycle after edge k (1 cycle).
REQ-012 Grant with GAP_CYCLES>0 -> GAP with counter=GAP_CYCLES.
REQ-013 GAP: decrement counter; reaching 0 -> READY.
REQ-014 GAP_CYCLES=0: back-to-back grants on consecutive cycles, alternating requesters.
REQ-015 Cycles with no grant: out_InstructionType=CMD_IDLE; StreamID/ChannelID/Parameter hold last value.
REQ-016 pause=1 in READY: no grant, no pointer change.
REQ-017 pause=1 in GAP: countdown continues.
REQ-018 Requester holds fields stable while req_Valid=1 until it samples req_Ack=1.
REQ-019 A requester deasserting valid before grant loses its request; no ack produced.
REQ-020 At most one req_Ack bit high per cycle.

Reset
REQ-021 rstnIn low asynchronously clears: out_InstructionType=CMD_IDLE; out StreamID/ChannelID/Parameter=0; req_Ack=0; issueCount=0; both pointers=0; state=READY; gap counter=0.
REQ-022 Reset mid-GAP or mid-ack: aborted instruction not reissued; no ack on release.
REQ-023 First grant possible on first clock edge after rstnIn deasserts.

Structure
REQ-024 Shared package holds instruction encodings (IDLE=0, REQUEST=2, LOOKAHEAD=3, REWIND=5, RESTART=6, FINISH=7) and the urgent-class decode function.
REQ-025 One sub-module rr_pick: NUM_REQ-wide combinational round-robin picker (mask, pointer -> one-hot, found); instantiated twice, once per class.

Verification
REQ-026 Reqs 0 and 2 both REQUEST, GAP_CYCLES=0 -> issues req 0 then req 2; acks on consecutive cycles; issueCount=2.
REQ-027 Req 1 REQUEST and req 3 FINISH same cycle -> req 3 issued first (type 7), req 1 next cycle.
REQ-028 All 4 normal requesters held valid, 8 grants -> order 0,1,2,3,0,1,2,3; no double ack while valid is held through its ack cycle.
REQ-029 GAP_CYCLES=2, reqs 0 and 1 valid -> issue, IDLE, IDLE, issue; pause=1 for 3 cycles in READY -> output IDLE, pointers unchanged.
REQ-030 rstnIn low in cycle after grant with GAP_CYCLES=3 -> outputs reset immediately; after release, pending request re-granted once.
REQ-031 Req 2 type 1 (undefined) held 10 cycles -> never acked; output stays IDLE.

Source files
------------

// File: rtl/instr_arbiter_pkg.sv
// rtl/instr_arbiter_pkg.sv - instruction encodings and class decode shared by the arbiter
package instr_arbiter_pkg;

    localparam int CMD_IDLE      = 0;
    localparam int CMD_REQUEST   = 2;
    localparam int CMD_LOOKAHEAD = 3;
    localparam int CMD_REWIND    = 5;
    localparam int CMD_RESTART   = 6;
    localparam int CMD_FINISH    = 7;

    localparam int GAP_CNT_WIDTH = 4;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_GAP   = 1'b1
    } arb_state_e;

    function automatic logic is_urgent(input logic [31:0] t);
        return (t == 32'(CMD_REWIND)) || (t == 32'(CMD_RESTART)) || (t == 32'(CMD_FINISH));
    endfunction

    function automatic logic is_normal(input logic [31:0] t);
        return (t == 32'(CMD_REQUEST)) || (t == 32'(CMD_LOOKAHEAD));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set mask bit at or after the pointer
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_mask,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_found
);

    // One spare bit so ptr+offset never overflows before the wrap correction.
    logic [PW:0] w_pos;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        w_pos    = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_pos >= (PW+1)'(N)) begin
                w_pos = w_pos - (PW+1)'(N);
            end
            if (!o_found && i_mask[w_pos[PW-1:0]]) begin
                o_found                  = 1'b1;
                o_onehot[w_pos[PW-1:0]] = 1'b1;
                o_idx                    = w_pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/instr_arbiter.sv
// rtl/instr_arbiter.sv - two-class round-robin instruction arbiter with optional post-issue gap
module instr_arbiter
    import instr_arbiter_pkg::*;
#(
    parameter int NUM_REQ                     = 4,
    parameter int INSTRUCTION_WIDTH           = 3,
    parameter int STREAM_ID_WIDTH             = 4,
    parameter int CHANNEL_ID_WIDTH            = 10,
    parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
    parameter int GAP_CYCLES                  = 0
) (
    input  logic                                             clk,
    input  logic                                             rstnIn,
    input  logic [NUM_REQ-1:0]                               req_Valid,
    input  logic [NUM_REQ*INSTRUCTION_WIDTH-1:0]             req_InstructionType,
    input  logic [NUM_REQ*STREAM_ID_WIDTH-1:0]               req_InstructionStreamID,
    input  logic [NUM_REQ*CHANNEL_ID_WIDTH-1:0]              req_InstructionChannelID,
    input  logic [NUM_REQ*INSTRUCTION_PARAMETER_WIDTH-1:0]   req_InstructionParameter,
    output logic [NUM_REQ-1:0]                               req_Ack,
    input  logic                                             pause,
    output logic [INSTRUCTION_WIDTH-1:0]                     out_InstructionType,
    output logic [STREAM_ID_WIDTH-1:0]                       out_InstructionStreamID,
    output logic [CHANNEL_ID_WIDTH-1:0]                      out_InstructionChannelID,
    output logic [INSTRUCTION_PARAMETER_WIDTH-1:0]           out_InstructionParameter,
    output logic [31:0]                                      issueCount
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e                               r_state;
    logic [GAP_CNT_WIDTH-1:0]                 r_gap_cnt;
    logic [PW-1:0]                            r_ptr_urg;
    logic [PW-1:0]                            r_ptr_norm;
    logic [NUM_REQ-1:0]                       r_ack;
    logic [INSTRUCTION_WIDTH-1:0]             r_type;
    logic [STREAM_ID_WIDTH-1:0]               r_sid;
    logic [CHANNEL_ID_WIDTH-1:0]              r_cid;
    logic [INSTRUCTION_PARAMETER_WIDTH-1:0]   r_par;
    logic [31:0]                              r_count;

    logic [NUM_REQ-1:0]                       w_mask_urg;
    logic [NUM_REQ-1:0]                       w_mask_norm;
    logic [NUM_REQ-1:0]                       w_onehot_urg;
    logic [NUM_REQ-1:0]                       w_onehot_norm;
    logic [PW-1:0]                            w_idx_urg;
    logic [PW-1:0]                            w_idx_norm;
    logic                                     w_found_urg;
    logic                                     w_found_norm;
    logic                                     w_grant;
    logic [NUM_REQ-1:0]                       w_win_onehot;
    logic [PW-1:0]                            w_win_idx;
    logic [PW-1:0]                            w_next_ptr;
    logic [INSTRUCTION_WIDTH-1:0]             w_win_type;
    logic [STREAM_ID_WIDTH-1:0]               w_win_sid;
    logic [CHANNEL_ID_WIDTH-1:0]              w_win_cid;
    logic [INSTRUCTION_PARAMETER_WIDTH-1:0]   w_win_par;

    // A requester being acked this cycle is excluded so a held valid is not granted twice.
    always_comb begin
        w_mask_urg  = '0;
        w_mask_norm = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask_urg[i]  = req_Valid[i] && !r_ack[i] &&
                is_urgent(32'(req_InstructionType[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH]));
            w_mask_norm[i] = req_Valid[i] && !r_ack[i] &&
                is_normal(32'(req_InstructionType[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH]));
        end
    end

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_urg (
        .i_mask   (w_mask_urg),
        .i_ptr    (r_ptr_urg),
        .o_onehot (w_onehot_urg),
        .o_idx    (w_idx_urg),
        .o_found  (w_found_urg)
    );

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_norm (
        .i_mask   (w_mask_norm),
        .i_ptr    (r_ptr_norm),
        .o_onehot (w_onehot_norm),
        .o_idx    (w_idx_norm),
        .o_found  (w_found_norm)
    );

    assign w_grant      = (r_state == ST_READY) && !pause && (w_found_urg || w_found_norm);
    assign w_win_onehot = w_found_urg ? w_onehot_urg : w_onehot_norm;
    assign w_win_idx    = w_found_urg ? w_idx_urg : w_idx_norm;
    assign w_next_ptr   = (w_win_idx == PW'(NUM_REQ-1)) ? '0 : w_win_idx + 1'b1;

    assign w_win_type = req_InstructionType[int'(w_win_idx)*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
    assign w_win_sid  = req_InstructionStreamID[int'(w_win_idx)*STREAM_ID_WIDTH +: STREAM_ID_WIDTH];
    assign w_win_cid  = req_InstructionChannelID[int'(w_win_idx)*CHANNEL_ID_WIDTH +: CHANNEL_ID_WIDTH];
    assign w_win_par  = req_InstructionParameter[int'(w_win_idx)*INSTRUCTION_PARAMETER_WIDTH +:
                                                 INSTRUCTION_PARAMETER_WIDTH];

    always_ff @(posedge clk or negedge rstnIn) begin
        if (!rstnIn) begin
            r_state    <= ST_READY;
            r_gap_cnt  <= '0;
            r_ptr_urg  <= '0;
            r_ptr_norm <= '0;
            r_ack      <= '0;
            r_type     <= INSTRUCTION_WIDTH'(CMD_IDLE);
            r_sid      <= '0;
            r_cid      <= '0;
            r_par      <= '0;
            r_count    <= '0;
        end else begin
            r_ack  <= '0;
            r_type <= INSTRUCTION_WIDTH'(CMD_IDLE);
            case (r_state)
                ST_READY: begin
                    if (w_grant) begin
                        r_ack   <= w_win_onehot;
                        r_type  <= w_win_type;
                        r_sid   <= w_win_sid;
                        r_cid   <= w_win_cid;
                        r_par   <= w_win_par;
                        r_count <= r_count + 32'd1;
                        if (w_found_urg) begin
                            r_ptr_urg <= w_next_ptr;
                        end else begin
                            r_ptr_norm <= w_next_ptr;
                        end
                        if (GAP_CYCLES > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_CNT_WIDTH'(GAP_CYCLES);
                        end
                    end
                end
                ST_GAP: begin
                    // Pause does not stall the countdown.
                    r_gap_cnt <= r_gap_cnt - 1'b1;
                    if (r_gap_cnt <= GAP_CNT_WIDTH'(1)) begin
                        r_state <= ST_READY;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                end
            endcase
        end
    end

    assign req_Ack                  = r_ack;
    assign out_InstructionType      = r_type;
    assign out_InstructionStreamID  = r_sid;
    assign out_InstructionChannelID = r_cid;
    assign out_InstructionParameter = r_par;
    assign issueCount               = r_count;

endmodule

// File: tb/tb_instr_arbiter.sv
// tb/tb_instr_arbiter.sv - directed and random checks of instr_arbiter at gap 0, 2 and 3
module tb_instr_arbiter;

    localparam int N  = 4;
    localparam int NI = 3;
    localparam int GAPV [NI] = '{0, 2, 3};

    logic clk;
    logic rstn;
    logic pause;
    logic [N-1:0] valid;
    logic [2:0]   typ [N];
    logic [3:0]   sid [N];
    logic [9:0]   cid [N];
    logic [15:0]  par [N];

    logic [N*3-1:0]  p_type;
    logic [N*4-1:0]  p_sid;
    logic [N*10-1:0] p_cid;
    logic [N*16-1:0] p_par;

    logic [N-1:0] d_ack  [NI];
    logic [2:0]   d_type [NI];
    logic [3:0]   d_sid  [NI];
    logic [9:0]   d_cid  [NI];
    logic [15:0]  d_par  [NI];
    logic [31:0]  d_cnt  [NI];

    int           m_gap  [NI];
    int           m_pu   [NI];
    int           m_pn   [NI];
    logic [N-1:0] m_ack  [NI];
    logic [2:0]   m_type [NI];
    logic [3:0]   m_sid  [NI];
    logic [9:0]   m_cid  [NI];
    logic [15:0]  m_par  [NI];
    logic [31:0]  m_cnt  [NI];

    int n_tests = 0;
    int n_fail  = 0;
    bit autodrop = 1'b0;

    always_comb begin
        p_type = '0;
        p_sid  = '0;
        p_cid  = '0;
        p_par  = '0;
        for (int i = 0; i < N; i++) begin
            p_type[i*3 +: 3]   = typ[i];
            p_sid[i*4 +: 4]    = sid[i];
            p_cid[i*10 +: 10]  = cid[i];
            p_par[i*16 +: 16]  = par[i];
        end
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        instr_arbiter #(
            .NUM_REQ(N), .INSTRUCTION_WIDTH(3), .STREAM_ID_WIDTH(4),
            .CHANNEL_ID_WIDTH(10), .INSTRUCTION_PARAMETER_WIDTH(16), .GAP_CYCLES(GAPV[g])
        ) u_dut (
            .clk                      (clk),
            .rstnIn                   (rstn),
            .req_Valid                (valid),
            .req_InstructionType      (p_type),
            .req_InstructionStreamID  (p_sid),
            .req_InstructionChannelID (p_cid),
            .req_InstructionParameter (p_par),
            .req_Ack                  (d_ack[g]),
            .pause                    (pause),
            .out_InstructionType      (d_type[g]),
            .out_InstructionStreamID  (d_sid[g]),
            .out_InstructionChannelID (d_cid[g]),
            .out_InstructionParameter (d_par[g]),
            .issueCount               (d_cnt[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 2 = urgent, 1 = normal, 0 = never granted
    function automatic int cls_of(input logic [2:0] t);
        if (t >= 3'd5) return 2;
        if (t == 3'd2 || t == 3'd3) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            m_gap[g] = 0; m_pu[g] = 0; m_pn[g] = 0; m_ack[g] = '0;
            m_type[g] = '0; m_sid[g] = '0; m_cid[g] = '0; m_par[g] = '0; m_cnt[g] = '0;
        end
    endtask

    task automatic model_step();
        for (int g = 0; g < NI; g++) begin
            int win;
            int best;
            int cls_won;
            win = -1;
            best = N;
            cls_won = 0;
            if (m_gap[g] > 0) begin
                m_gap[g]--;
            end else if (!pause) begin
                for (int cls = 2; cls >= 1; cls--) begin
                    if (win < 0) begin
                        int ptr;
                        ptr = (cls == 2) ? m_pu[g] : m_pn[g];
                        for (int i = 0; i < N; i++) begin
                            if (valid[i] && !m_ack[g][i] && cls_of(typ[i]) == cls &&
                                ((i - ptr + N) % N) < best) begin
                                best = (i - ptr + N) % N;
                                win = i;
                                cls_won = cls;
                            end
                        end
                    end
                end
            end
            if (win >= 0) begin
                m_ack[g]  = N'(1) << win;
                m_type[g] = typ[win];
                m_sid[g]  = sid[win];
                m_cid[g]  = cid[win];
                m_par[g]  = par[win];
                m_cnt[g]  = m_cnt[g] + 1;
                if (cls_won == 2) m_pu[g] = (win + 1) % N;
                else              m_pn[g] = (win + 1) % N;
                m_gap[g] = GAPV[g];
            end else begin
                m_ack[g]  = '0;
                m_type[g] = '0;
            end
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("ack[g%0d]", g),   32'(d_ack[g]),  32'(m_ack[g]));
            chk($sformatf("type[g%0d]", g),  32'(d_type[g]), 32'(m_type[g]));
            chk($sformatf("sid[g%0d]", g),   32'(d_sid[g]),  32'(m_sid[g]));
            chk($sformatf("cid[g%0d]", g),   32'(d_cid[g]),  32'(m_cid[g]));
            chk($sformatf("par[g%0d]", g),   32'(d_par[g]),  32'(m_par[g]));
            chk($sformatf("count[g%0d]", g), d_cnt[g],       m_cnt[g]);
            chk($sformatf("onehot[g%0d]", g), 32'($onehot0(d_ack[g])), 32'd1);
        end
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase.
    task automatic tick();
        logic [N-1:0] prev_ack;
        prev_ack = m_ack[0];
        if (rstn) model_step();
        @(posedge clk);
        #1;
        check_all();
        if (autodrop) begin
            for (int i = 0; i < N; i++) begin
                if (prev_ack[i]) valid[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [2:0] t);
        valid[i] = 1'b1;
        typ[i]   = t;
        sid[i]   = 4'($urandom());
        cid[i]   = 10'($urandom());
        par[i]   = 16'($urandom());
    endtask

    initial begin
        rstn  = 1'b0;
        pause = 1'b0;
        valid = '0;
        for (int i = 0; i < N; i++) begin
            typ[i] = '0; sid[i] = '0; cid[i] = '0; par[i] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // two normal requesters, gap 0: 0 then 2 on consecutive cycles
        autodrop = 1'b1;
        set_req(0, 3'd2);
        set_req(2, 3'd2);
        tick(); chk("r026_first_ack", 32'(d_ack[0]), 32'b0001);
        tick(); chk("r026_second_ack", 32'(d_ack[0]), 32'b0100);
        tick();
        tick(); chk("r026_count", d_cnt[0], 32'd2);

        // urgent beats normal
        do_reset();
        set_req(1, 3'd2);
        set_req(3, 3'd7);
        tick(); chk("r027_urgent_ack", 32'(d_ack[0]), 32'b1000);
        chk("r027_urgent_type", 32'(d_type[0]), 32'd7);
        tick(); chk("r027_normal_ack", 32'(d_ack[0]), 32'b0010);
        chk("r027_normal_type", 32'(d_type[0]), 32'd2);
        tick();
        tick();

        // all normal requesters held valid: strict rotation, no double ack
        do_reset();
        autodrop = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 3'd2);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("r028_order%0d", k), 32'(d_ack[0]), 32'(1) << (k % 4));
        end
        valid = '0;
        tick();

        // gap 2: issue, idle, idle, issue; then pause across gap and ready
        do_reset();
        set_req(0, 3'd2);
        set_req(1, 3'd3);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("r029_type%0d", k), 32'(d_type[1]),
                (k == 0) ? 32'd2 : ((k == 3) ? 32'd3 : 32'd0));
            chk($sformatf("r029_ack%0d", k), 32'(d_ack[1]),
                (k == 0) ? 32'b0001 : ((k == 3) ? 32'b0010 : 32'b0000));
        end
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("r029_pause_type%0d", k), 32'(d_type[1]), 32'd0);
        end
        pause = 1'b0;
        tick(); chk("r029_resume_ack", 32'(d_ack[1]), 32'b0001);
        valid = '0;
        tick();

        // reset in the ack cycle with gap 3: pending request granted once after release
        do_reset();
        autodrop = 1'b1;
        set_req(0, 3'd5);
        tick(); chk("r030_pre_ack", 32'(d_ack[2]), 32'b0001);
        do_reset();
        chk("r030_reset_count", d_cnt[2], 32'd0);
        tick(); chk("r030_regrant_ack", 32'(d_ack[2]), 32'b0001);
        for (int k = 0; k < 5; k++) tick();
        chk("r030_once_count", d_cnt[2], 32'd1);

        // undefined type never acked
        do_reset();
        set_req(2, 3'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("r031_ack%0d", k), 32'(d_ack[0]), 32'd0);
            chk($sformatf("r031_type%0d", k), 32'(d_type[0]), 32'd0);
        end
        valid = '0;

        // random traffic, withdrawals, pauses and occasional resets
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 3'($urandom_range(0, 7)));
                end else if (valid[i] && !m_ack[0][i] && $urandom_range(0, 15) == 0) begin
                    valid[i] = 1'b0;
                end
            end
            pause = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
